pipelined_cla_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead add/subtract unit; successor to the single-cycle CLA adder.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_group.sv | 45 ++++
 rtl/pipelined_cla_adder.sv | 166 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead add/subtract unit.
// Group propagate/generate travels as one packed struct between the group cells and the lookahead.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } cla_op_e;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  function automatic int num_groups(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational BLOCK-bit carry-lookahead group.
// Produces the local sum, group propagate/generate and the carry into the group MSB.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output grp_pg_t          pg,
  output logic             c_msb
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] c;
  logic             gg;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < BLOCK; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
  end

  // Kept apart from the carry chain so group P/G never depends on cin.
  always_comb begin
    gg = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      gg = g[i] | (p[i] & gg);
    end
  end

  assign sum   = p ^ c;
  assign pg.p  = &p;
  assign pg.g  = gg;
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit with valid/ready flow control.
// Each stage resolves NG/STAGES groups; low result bits and unconsumed operand bits ride forward.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int NG  = num_groups(WIDTH, BLOCK);
  localparam int GPS = NG / STAGES;
  localparam int SW  = GPS * BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_chk_block
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK");
  end
  if (STAGES < 1 || STAGES > NG || NG % STAGES != 0) begin : g_chk_stages
    $error("pipelined_cla_adder: STAGES must divide WIDTH/BLOCK and lie in 1..WIDTH/BLOCK");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // o_ready depends only on stage valids and i_ready, never on i_valid.
  logic [STAGES-1:0] vld_vec;
  logic [STAGES:0]   ld;

  always_comb begin
    ld         = '0;
    ld[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !vld_vec[k] | ld[k+1];
    end
  end

  assign o_ready = ld[0];

  // Subtraction is folded in at the entry: B is inverted and the borrow becomes carry-in,
  // so later stages only ever add and the mode need not travel further.
  cla_op_e          op;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign op    = i_sub ? OP_SUB : OP_ADD;
  assign b_eff = (op == OP_SUB) ? ~i_add2 : i_add2;
  assign c_eff = (op == OP_SUB) ? ~i_cin : i_cin;

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int LO = s * SW;
    localparam int HI = LO + SW;

    logic [SW-1:0]      a_cur;
    logic [SW-1:0]      b_cur;
    logic [SW-1:0]      sum_cur;
    logic               c_cur;
    logic               v_cur;
    grp_pg_t [GPS-1:0]  pg;
    logic [GPS:0]       gc;
    logic [GPS-1:0]     msb_c;
    logic [HI-1:0]      sum_nxt;
    logic               vld_q;
    logic               c_q;
    logic [HI-1:0]      sum_q;

    assign vld_vec[s] = vld_q;

    if (s == 0) begin : g_src
      assign a_cur   = i_add1[SW-1:0];
      assign b_cur   = b_eff[SW-1:0];
      assign c_cur   = c_eff;
      assign v_cur   = i_valid;
      assign sum_nxt = sum_cur;
    end else begin : g_src
      assign a_cur   = stg[s-1].g_rem.a_q[SW-1:0];
      assign b_cur   = stg[s-1].g_rem.b_q[SW-1:0];
      assign c_cur   = stg[s-1].c_q;
      assign v_cur   = vld_vec[s-1];
      assign sum_nxt = {sum_cur, stg[s-1].sum_q};
    end

    for (genvar g = 0; g < GPS; g++) begin : grp
      cla_group #(
        .BLOCK(BLOCK)
      ) u_grp (
        .a    (a_cur[g*BLOCK +: BLOCK]),
        .b    (b_cur[g*BLOCK +: BLOCK]),
        .cin  (gc[g]),
        .sum  (sum_cur[g*BLOCK +: BLOCK]),
        .pg   (pg[g]),
        .c_msb(msb_c[g])
      );
    end

    always_comb begin
      gc    = '0;
      gc[0] = c_cur;
      for (int g = 0; g < GPS; g++) begin
        gc[g+1] = pg[g].g | (pg[g].p & gc[g]);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (ld[s]) begin
        vld_q <= v_cur;
        c_q   <= gc[GPS];
        sum_q <= sum_nxt;
      end
    end

    if (s < STAGES - 1) begin : g_rem
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      logic [WIDTH-HI-1:0] a_nxt;
      logic [WIDTH-HI-1:0] b_nxt;

      if (s == 0) begin : g_nxt
        assign a_nxt = i_add1[WIDTH-1:HI];
        assign b_nxt = b_eff[WIDTH-1:HI];
      end else begin : g_nxt
        assign a_nxt = stg[s-1].g_rem.a_q[WIDTH-LO-1:SW];
        assign b_nxt = stg[s-1].g_rem.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld[s]) begin
          a_q <= a_nxt;
          b_q <= b_nxt;
        end
      end
    end else begin : g_ovf
      logic ov_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ov_q <= 1'b0;
        end else if (ld[s]) begin
          ov_q <= msb_c[GPS-1] ^ gc[GPS];
        end
      end
    end
  end

  assign o_valid    = vld_vec[STAGES-1];
  assign o_result   = {stg[STAGES-1].c_q, stg[STAGES-1].sum_q};
  assign o_overflow = stg[STAGES-1].g_ovf.ov_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: a 16/4/2 instance for directed and stall/reset scenarios,
// and a 4/2/2 instance swept exhaustively; results are scored against a behavioural model.
module tb_pipelined_cla_adder;

  localparam int W   = 16;
  localparam int WS  = 4;
  localparam int LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16-bit instance
  logic         a_valid, a_ready, a_cin, a_sub, a_ovalid, a_iready, a_ovf;
  logic [W-1:0] a_add1, a_add2;
  logic [W:0]   a_result;

  // 4-bit instance
  logic          b_valid, b_ready, b_cin, b_sub, b_ovalid, b_iready, b_ovf;
  logic [WS-1:0] b_add1, b_add2;
  logic [WS:0]   b_result;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(2)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_add1(a_add1), .i_add2(a_add2), .i_cin(a_cin), .i_sub(a_sub),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_result(a_result), .o_overflow(a_ovf)
  );

  pipelined_cla_adder #(.WIDTH(WS), .BLOCK(2), .STAGES(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_add1(b_add1), .i_add2(b_add2), .i_cin(b_cin), .i_sub(b_sub),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_result(b_result), .o_overflow(b_ovf)
  );

  // scoreboard: {overflow, result}
  logic [W+1:0]  exp_q[$];
  logic [WS+1:0] exp_s_q[$];
  int errors = 0;
  int checks = 0;

  logic a_acc, b_acc, stall_arm;
  int   a_pops, b_pops, stall_left, nready_cycles, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] mask, bb;
    logic [32:0] r;
    logic        cc, ov;
    mask = (32'd1 << w) - 32'd1;
    bb   = (sub ? ~b : b) & mask;
    cc   = sub ? ~cin : cin;
    r    = {1'b0, a & mask} + {1'b0, bb} + {32'd0, cc};
    ov   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    return {ov, r[31:0] & ((mask << 1) | 32'd1)};
  endfunction

  // One clock: score transfers at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [W+1:0]  e;
    logic [WS+1:0] es;
    logic [32:0]   m;
    @(negedge clk);
    a_acc = a_valid && a_ready && !rst;
    b_acc = b_valid && b_ready && !rst;
    if (a_ovalid && a_iready && !rst) begin
      a_pops++;
      check("a_result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("a_result", 32'(a_result), 32'(e[W:0]));
        check("a_overflow", 32'(a_ovf), 32'(e[W+1]));
      end
    end
    if (b_ovalid && b_iready && !rst) begin
      b_pops++;
      check("b_result_expected", 32'(exp_s_q.size() != 0), 32'd1);
      if (exp_s_q.size() != 0) begin
        es = exp_s_q.pop_front();
        check("b_result", 32'(b_result), 32'(es[WS:0]));
        check("b_overflow", 32'(b_ovf), 32'(es[WS+1]));
      end
    end
    if (a_acc) begin
      m = model(W, 32'(a_add1), 32'(a_add2), a_cin, a_sub);
      exp_q.push_back({m[32], m[W:0]});
    end
    if (b_acc) begin
      m = model(WS, 32'(b_add1), 32'(b_add2), b_cin, b_sub);
      exp_s_q.push_back({m[32], m[WS:0]});
    end
    if (stall_left > 0 && !a_ready) nready_cycles++;
    @(posedge clk);
    #1;
    cyc++;
    if (stall_arm && a_ovalid) begin
      stall_arm  = 1'b0;
      stall_left = 3;
      a_iready   = 1'b0;
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) a_iready = 1'b1;
    end
  endtask

  // driver tasks: hold operands until accepted
  task automatic send_a(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n = 0;
    a_valid = 1'b1; a_add1 = a; a_add2 = b; a_cin = cin; a_sub = sub;
    do begin
      tick();
      n++;
    end while (!a_acc && n < 64);
    check("a_accept", 32'(a_acc), 32'd1);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic cin, input logic sub);
    int n = 0;
    b_valid = 1'b1; b_add1 = a; b_add2 = b; b_cin = cin; b_sub = sub;
    do begin
      tick();
      n++;
    end while (!b_acc && n < 64);
    check("b_accept", 32'(b_acc), 32'd1);
    b_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    check("a_drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (LAT + 1) tick();
  endtask

  task automatic drain_b();
    int n = 0;
    while (exp_s_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    check("b_drain_empty", 32'(exp_s_q.size()), 32'd0);
    repeat (LAT + 1) tick();
  endtask

  // One isolated op with a fixed expected answer and latency.
  task automatic dir_a(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W:0] res, input logic ov);
    int lat;
    send_a(a, b, cin, sub);
    lat = 1;
    while (!a_ovalid && lat < 16) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_result"}, 32'(a_result), 32'(res));
    check({tag, "_ovf"}, 32'(a_ovf), 32'(ov));
    drain_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, c0;
    rst = 1'b1;
    a_valid = 1'b0; a_add1 = '0; a_add2 = '0; a_cin = 1'b0; a_sub = 1'b0; a_iready = 1'b1;
    b_valid = 1'b0; b_add1 = '0; b_add2 = '0; b_cin = 1'b0; b_sub = 1'b0; b_iready = 1'b1;
    a_acc = 1'b0; b_acc = 1'b0; stall_arm = 1'b0;
    a_pops = 0; b_pops = 0; stall_left = 0; nready_cycles = 0; cyc = 0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check("rst_a_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_a_result", 32'(a_result), 32'd0);
    check("rst_a_ovf", 32'(a_ovf), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ovalid", 32'(b_ovalid), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd1);

    // directed arithmetic
    dir_a("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    dir_a("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
    dir_a("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0);
    dir_a("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
    dir_a("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
    dir_a("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0);
    dir_a("sub_bin", 16'h0010, 16'h0001, 1'b1, 1'b1, 17'h1000E, 1'b0);
    dir_a("add_negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1);

    // back-to-back stream with a 3-cycle output stall
    p0 = a_pops;
    nready_cycles = 0;
    stall_arm = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_a(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain_a();
    check("stall_not_ready_cycles", 32'(nready_cycles), 32'd3);
    check("stall_result_count", 32'(a_pops - p0), 32'd6);
    check("stall_ready_back", 32'(a_iready), 32'd1);

    // reset with two ops in flight
    a_iready = 1'b0;
    send_a(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    send_a(16'h1111, 16'h2222, 1'b1, 1'b1);
    check("inflight_full", 32'(a_ovalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("midrst_ovalid", 32'(a_ovalid), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd1);
    check("midrst_result", 32'(a_result), 32'd0);
    a_iready = 1'b1;
    p0 = a_pops;
    dir_a("post_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 17'h00406, 1'b0);
    check("post_rst_count", 32'(a_pops - p0), 32'd1);

    // exhaustive 4-bit sweep at full throughput
    p0 = b_pops;
    c0 = cyc;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int ci = 0; ci < 2; ci++) begin
          for (int sb = 0; sb < 2; sb++) begin
            send_b(WS'(x), WS'(y), 1'(ci), 1'(sb));
          end
        end
      end
    end
    check("sweep_cycles", 32'(cyc - c0), 32'd1024);
    check("sweep_pops_inflight", 32'(b_pops - p0), 32'(1024 - LAT));
    drain_b();
    check("sweep_total", 32'(b_pops - p0), 32'd1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
